// File: rtl/mem_port_arbiter_2x32.sv
// Two-requester arbiter onto one single-port 32-bit synchronous memory.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (r0 first).
module mem_port_arbiter_2x32 #(
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  r0_req,
    input  logic                  r0_rw,
    input  logic [ADDR_WIDTH-1:0] r0_address,
    input  logic [31:0]           r0_write_data,
    input  logic [3:0]            r0_byte_en,
    output logic                  r0_ack,
    output logic [31:0]           r0_read_data,
    input  logic                  r1_req,
    input  logic                  r1_rw,
    input  logic [ADDR_WIDTH-1:0] r1_address,
    input  logic [31:0]           r1_write_data,
    input  logic [3:0]            r1_byte_en,
    output logic                  r1_ack,
    output logic [31:0]           r1_read_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic [3:0]            mem_byte_en,
    output logic                  mem_wren,
    input  logic [31:0]           mem_read_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        ACK
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        winner;
    logic [3:0]  cnt;
    logic        req_any;
    logic        grant_id;
    logic        grant_rw;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    // Contested grant goes to whoever did not win last time.
    always_comb begin
        grant_id = ~r0_req;
        if (r0_req && r1_req) begin
            grant_id = ~last;
        end
    end
`else
    always_comb begin
        grant_id = ~r0_req;
    end
`endif

    assign req_any  = r0_req | r1_req;
    assign grant_rw = grant_id ? r1_rw : r0_rw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_any) begin
                    state_nxt = grant_rw ? READ : WRITE;
                end
            end
            READ: begin
                if (cnt == LAT_M1) begin
                    state_nxt = ACK;
                end
            end
            WRITE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            winner         <= 1'b0;
            cnt            <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_byte_en    <= '0;
            r0_read_data   <= '0;
            r1_read_data   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last           <= 1'b1;
`endif
        end else begin
            if (state == IDLE && req_any) begin
                winner         <= grant_id;
                cnt            <= '0;
                mem_address    <= grant_id ? r1_address    : r0_address;
                mem_write_data <= grant_id ? r1_write_data : r0_write_data;
                mem_byte_en    <= grant_id ? r1_byte_en    : r0_byte_en;
`ifdef ARB_ROUND_ROBIN_EN
                last           <= grant_id;
`endif
            end
            if (state == READ) begin
                cnt <= cnt + 4'd1;
                if (cnt == LAT_M1) begin
                    if (winner) begin
                        r1_read_data <= mem_read_data;
                    end else begin
                        r0_read_data <= mem_read_data;
                    end
                end
            end
        end
    end

    assign mem_wren = (state == WRITE);
    assign busy     = (state != IDLE);
    assign r0_ack   = (state == ACK) && !winner;
    assign r1_ack   = (state == ACK) && winner;

endmodule

// File: tb/tb_mem_port_arbiter_2x32.sv
// Scoreboard bench for mem_port_arbiter_2x32: main instance at READ_LATENCY=2,
// second instance at READ_LATENCY=5 for the latency/capture-window case.
module tb_mem_port_arbiter_2x32;

    localparam int RL = 2;

    typedef struct {
        int          id;
        logic        rw;
        logic [31:0] rdata;
        int          cyc;
    } ack_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        int          cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        r0_req = 0, r0_rw = 0, r1_req = 0, r1_rw = 0;
    logic [31:0] r0_address = 0, r0_write_data = 0, r1_address = 0, r1_write_data = 0;
    logic [3:0]  r0_byte_en = 0, r1_byte_en = 0;
    logic        r0_ack, r1_ack, mem_wren, busy;
    logic [31:0] r0_read_data, r1_read_data, mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_byte_en;

    logic        b_r0_req = 0, b_r0_rw = 0, b_r1_req = 0, b_r1_rw = 0;
    logic [31:0] b_r0_address = 0, b_r0_write_data = 0, b_r1_address = 0, b_r1_write_data = 0;
    logic [3:0]  b_r0_byte_en = 0, b_r1_byte_en = 0;
    logic        b_r0_ack, b_r1_ack, b_mem_wren, b_busy;
    logic [31:0] b_r0_read_data, b_r1_read_data, b_mem_address, b_mem_write_data;
    logic [31:0] b_mem_read_data = 0;
    logic [3:0]  b_mem_byte_en;

    ack_t aq[$];
    ack_t q5[$];
    wr_t  wq[$];

    mem_port_arbiter_2x32 #(.ADDR_WIDTH(32), .READ_LATENCY(RL)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_address(r0_address),
        .r0_write_data(r0_write_data), .r0_byte_en(r0_byte_en),
        .r0_ack(r0_ack), .r0_read_data(r0_read_data),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_address(r1_address),
        .r1_write_data(r1_write_data), .r1_byte_en(r1_byte_en),
        .r1_ack(r1_ack), .r1_read_data(r1_read_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_en(mem_byte_en), .mem_wren(mem_wren),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    mem_port_arbiter_2x32 #(.ADDR_WIDTH(32), .READ_LATENCY(5)) u_dut5 (
        .clk(clk), .reset_n(reset_n),
        .r0_req(b_r0_req), .r0_rw(b_r0_rw), .r0_address(b_r0_address),
        .r0_write_data(b_r0_write_data), .r0_byte_en(b_r0_byte_en),
        .r0_ack(b_r0_ack), .r0_read_data(b_r0_read_data),
        .r1_req(b_r1_req), .r1_rw(b_r1_rw), .r1_address(b_r1_address),
        .r1_write_data(b_r1_write_data), .r1_byte_en(b_r1_byte_en),
        .r1_ack(b_r1_ack), .r1_read_data(b_r1_read_data),
        .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
        .mem_byte_en(b_mem_byte_en), .mem_wren(b_mem_wren),
        .mem_read_data(b_mem_read_data), .busy(b_busy)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h10:  rom = 32'hDEAD_BEEF;
            32'h24:  rom = 32'hCAFE_F00D;
            32'h40:  rom = 32'h0101_0101;
            32'h44:  rom = 32'h0202_0202;
            32'h48:  rom = 32'h0303_0303;
            default: rom = 32'hEEEE_EEEE;
        endcase
    endfunction

    assign mem_read_data = rom(mem_address);

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_ack(input int id, input logic rw, input logic [31:0] rd, input int c);
        ack_t e;
        e.id = id; e.rw = rw; e.rdata = rd; e.cyc = c;
        aq.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input int c);
        wr_t e;
        e.a = a; e.d = d; e.be = be; e.cyc = c;
        wq.push_back(e);
    endtask

    // Ack monitor: every ack must match the next expected completion
    always @(negedge clk) begin
        ack_t e;
        if (r0_ack === 1'b1 && r1_ack === 1'b1) begin
            chk("dual_ack", 1, 0);
        end else if (r0_ack === 1'b1 || r1_ack === 1'b1) begin
            if (aq.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                e = aq.pop_front();
                chk("ack_id", r1_ack ? 1 : 0, e.id);
                chk("ack_cycle", cyc, e.cyc);
                if (e.rw) begin
                    chk("ack_rdata", r1_ack ? r1_read_data : r0_read_data, e.rdata);
                end
            end
        end
    end

    // Write-strobe monitor
    always @(negedge clk) begin
        wr_t e;
        if (mem_wren === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_wren", 1, 0);
            end else begin
                e = wq.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", mem_address, e.a);
                chk("wr_data", mem_write_data, e.d);
                chk("wr_be", {28'd0, mem_byte_en}, {28'd0, e.be});
            end
        end
    end

    // Monitor for the READ_LATENCY=5 instance
    always @(negedge clk) begin
        ack_t e;
        if (b_r1_ack === 1'b1) chk("l5_unexpected_r1_ack", 1, 0);
        if (b_mem_wren === 1'b1) chk("l5_unexpected_wren", 1, 0);
        if (b_r0_ack === 1'b1) begin
            if (q5.size() == 0) begin
                chk("l5_unexpected_ack", 1, 0);
            end else begin
                e = q5.pop_front();
                chk("l5_ack_cycle", cyc, e.cyc);
                chk("l5_rdata", b_r0_read_data, e.rdata);
            end
        end
    end

    task automatic issue(input int id, input logic rw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        int n;
        if (id == 0) begin
            r0_rw = rw; r0_address = a; r0_write_data = wd; r0_byte_en = be; r0_req = 1;
        end else begin
            r1_rw = rw; r1_address = a; r1_write_data = wd; r1_byte_en = be; r1_req = 1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((id == 0) ? r0_ack : r1_ack) && n < 200);
        if (n >= 200) chk("ack_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (id == 0) r0_req = 0;
        else r1_req = 0;
    endtask

    initial begin
        int n;
        int e;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {28'd0, r0_ack, r1_ack, mem_wren, busy}, 32'd0);
        chk("rst_rdata", r0_read_data | r1_read_data, 32'd0);
        chk("rst_mem", mem_address | mem_write_data | {28'd0, mem_byte_en}, 32'd0);
        reset_n = 1;
        @(posedge clk);
        #1;

        // Single read by r0
        push_ack(0, 1, 32'hDEAD_BEEF, cyc + 1 + RL);
        issue(0, 1, 32'h10, 32'h0, 4'hF);

        // Single write by r1
        push_wr(32'h20, 32'h1234_5678, 4'b0011, cyc + 1);
        push_ack(1, 0, 32'h0, cyc + 2);
        issue(1, 0, 32'h20, 32'h1234_5678, 4'b0011);

        // r1 requests while r0's read is in flight
        push_ack(0, 1, 32'hCAFE_F00D, cyc + 3);
        push_ack(1, 1, 32'hDEAD_BEEF, cyc + 7);
        fork
            issue(0, 1, 32'h24, 32'h0, 4'hF);
            begin
                @(posedge clk);
                #1;
                issue(1, 1, 32'h10, 32'h0, 4'h1);
            end
        join
        chk("r0_rdata_held", r0_read_data, 32'hCAFE_F00D);

        // Contention: r0 three reads, r1 two writes, all issued together
        e = cyc + 1;
`ifdef ARB_ROUND_ROBIN_EN
        push_ack(0, 1, 32'h0101_0101, e + 2);
        push_wr(32'h80, 32'hA0A0_0001, 4'b1111, e + 4);
        push_ack(1, 0, 32'h0, e + 5);
        push_ack(0, 1, 32'h0202_0202, e + 9);
        push_wr(32'h84, 32'hB0B0_0002, 4'b1100, e + 11);
        push_ack(1, 0, 32'h0, e + 12);
        push_ack(0, 1, 32'h0303_0303, e + 16);
`else
        push_ack(0, 1, 32'h0101_0101, e + 2);
        push_ack(0, 1, 32'h0202_0202, e + 6);
        push_ack(0, 1, 32'h0303_0303, e + 10);
        push_wr(32'h80, 32'hA0A0_0001, 4'b1111, e + 12);
        push_ack(1, 0, 32'h0, e + 13);
        push_wr(32'h84, 32'hB0B0_0002, 4'b1100, e + 15);
        push_ack(1, 0, 32'h0, e + 16);
`endif
        fork
            begin
                issue(0, 1, 32'h40, 32'h0, 4'hF);
                issue(0, 1, 32'h44, 32'h0, 4'hF);
                issue(0, 1, 32'h48, 32'h0, 4'hF);
            end
            begin
                issue(1, 0, 32'h80, 32'hA0A0_0001, 4'b1111);
                issue(1, 0, 32'h84, 32'hB0B0_0002, 4'b1100);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted during the WRITE cycle aborts the transaction
        push_wr(32'h30, 32'h5555_AAAA, 4'b1111, cyc + 1);
        r1_rw = 0; r1_address = 32'h30; r1_write_data = 32'h5555_AAAA;
        r1_byte_en = 4'b1111; r1_req = 1;
        @(posedge clk);
        #1;
        reset_n = 0;
        r1_req = 0;
        @(posedge clk);
        #1;
        chk("rst_mid_wren", {31'd0, mem_wren}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_ack", {30'd0, r0_ack, r1_ack}, 32'd0);
        chk("rst_mid_rdata", r0_read_data, 32'd0);
        reset_n = 1;
        repeat (3) @(posedge clk);
        #1;
        push_wr(32'h34, 32'h0F0F_0F0F, 4'b0101, cyc + 1);
        push_ack(1, 0, 32'h0, cyc + 2);
        issue(1, 0, 32'h34, 32'h0F0F_0F0F, 4'b0101);

        // READ_LATENCY=5: only the value present in T+5 is captured
        begin
            ack_t x;
            int t;
            t = cyc;
            x.id = 0; x.rw = 1; x.rdata = 32'h600D_600D; x.cyc = t + 6;
            q5.push_back(x);
            b_mem_read_data = 32'h1111_1111;
            b_r0_rw = 1; b_r0_address = 32'h100; b_r0_byte_en = 4'hF; b_r0_req = 1;
            repeat (4) @(posedge clk);
            #1;
            b_mem_read_data = 32'hBAD0_BAD0;
            @(posedge clk);
            #1;
            b_mem_read_data = 32'h600D_600D;
            @(posedge clk);
            #1;
            b_mem_read_data = 32'hFFFF_FFFF;
            n = 0;
            while (b_r0_ack !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) chk("l5_ack_timeout", 1, 0);
            @(posedge clk);
            #1;
            b_r0_req = 0;
            @(posedge clk);
            #1;
            chk("l5_rdata_held", b_r0_read_data, 32'h600D_600D);
        end

        n = 0;
        while ((aq.size() != 0 || wq.size() != 0 || q5.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        chk("ack_queue_drained", aq.size(), 0);
        chk("wr_queue_drained", wq.size(), 0);
        chk("l5_queue_drained", q5.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
